// File: rtl/lfsr_seq_monitor.sv
// rtl/lfsr_seq_monitor.sv - Galois LFSR sequence monitor: lock tracking, error count, loop period
// Optional zero-lockup detection is compiled in when LFSR_MON_ZERO_DET_EN is defined.
module lfsr_seq_monitor #(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED     = 16'hACE1,
  parameter int unsigned       RESYNC_N = 4
) (
  input  logic             CLK,
  input  logic             n_RESET,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q,
  output logic             locked,
  output logic [15:0]      err_count,
  output logic [16:0]      period,
  output logic             period_vld,
  output logic             zero_lock
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  localparam logic [3:0] RESYNC_L = 4'(RESYNC_N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic [3:0]       miss_q, miss_d;
  logic [16:0]      per_q, per_d;
  logic             armed_q, armed_d;
  logic [15:0]      err_q, err_d;
  logic [16:0]      period_q, period_d;
  logic             vld_q, vld_d;
  logic             q_bad;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

`ifdef LFSR_MON_ZERO_DET_EN
  logic zero_q, zero_d;

  // An all-zero sample can never be a legal LFSR state, so it always counts as a miss.
  assign q_bad  = (q != pred_q) || (q == '0);
  assign zero_d = zero_q | (sample_en && (q == '0));

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero_lock = zero_q;
`else
  assign q_bad     = (q != pred_q);
  assign zero_lock = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    miss_d   = miss_q;
    per_d    = per_q;
    armed_d  = armed_q;
    err_d    = err_q;
    period_d = period_q;
    vld_d    = 1'b0;
    if (sample_en) begin
      case (state_q)
        ST_SYNC: begin
          pred_d  = nxt(q);
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          pred_d = nxt(q);
          if (q == pred_q) begin
            state_d = ST_LOCK;
            miss_d  = 4'd0;
          end
        end
        ST_LOCK: begin
          if (q_bad) begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if (miss_q + 4'd1 == RESYNC_L) begin
              state_d = ST_ACQ;
              miss_d  = 4'd0;
              armed_d = 1'b0;
              per_d   = 17'd0;
              pred_d  = nxt(q);
            end else begin
              miss_d = miss_q + 4'd1;
              pred_d = nxt(pred_q);
            end
          end else begin
            // Prediction free-runs in lock so a single bad sample costs exactly one error.
            miss_d = 4'd0;
            pred_d = nxt(pred_q);
            if (q == SEED) begin
              if (armed_q) begin
                period_d = per_q;
                vld_d    = 1'b1;
              end
              per_d   = 17'd1;
              armed_d = 1'b1;
            end else if (armed_q && (per_q != 17'h1FFFF)) begin
              per_d = per_q + 17'd1;
            end
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_q  <= ST_SYNC;
      pred_q   <= '0;
      miss_q   <= 4'd0;
      per_q    <= 17'd0;
      armed_q  <= 1'b0;
      err_q    <= 16'd0;
      period_q <= 17'd0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      miss_q   <= miss_d;
      per_q    <= per_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

  assign locked     = (state_q == ST_LOCK);
  assign err_count  = err_q;
  assign period     = period_q;
  assign period_vld = vld_q;

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// tb/tb_lfsr_seq_monitor.sv - self-checking bench for lfsr_seq_monitor against a behavioural model
module tb_lfsr_seq_monitor;

  logic        CLK = 1'b0;
  logic        n_RESET = 1'b0;
  logic        sample_en = 1'b0;
  logic [15:0] q = 16'h0000;
  logic        locked;
  logic [15:0] err_count;
  logic [16:0] period;
  logic        period_vld;
  logic        zero_lock;

  int checks = 0;
  int failures = 0;

  lfsr_seq_monitor dut (
    .CLK(CLK), .n_RESET(n_RESET), .sample_en(sample_en), .q(q),
    .locked(locked), .err_count(err_count), .period(period),
    .period_vld(period_vld), .zero_lock(zero_lock)
  );

  always #5 CLK = ~CLK;

  logic [15:0] seq [0:65534];

  int          m_state;
  logic [15:0] m_pred;
  int          m_miss, m_per, m_err, m_period;
  bit          m_armed, m_vld, m_zero;

  wire [35:0] dut_vec = {locked, err_count, period, period_vld, zero_lock};

  function automatic logic [15:0] nxt_m(input logic [15:0] x);
    return (x / 16'd2) ^ (((x % 16'd2) == 16'd1) ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [35:0] model_vec();
    return {(m_state == 2), 16'(m_err), 17'(m_period), m_vld, m_zero};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pred = 0; m_miss = 0; m_per = 0; m_err = 0;
    m_period = 0; m_armed = 0; m_vld = 0; m_zero = 0;
  endtask

  task automatic model_step(input bit en, input logic [15:0] v);
    bit bad;
    m_vld = 0;
    if (!en) return;
    bad = (v != m_pred);
`ifdef LFSR_MON_ZERO_DET_EN
    if (v == 16'h0000) begin
      m_zero = 1;
      bad = 1;
    end
`endif
    if (m_state == 0) begin
      m_pred = nxt_m(v);
      m_state = 1;
    end else if (m_state == 1) begin
      if (v == m_pred) begin
        m_state = 2;
        m_miss = 0;
      end
      m_pred = nxt_m(v);
    end else if (bad) begin
      if (m_err < 65535) m_err++;
      m_miss++;
      if (m_miss == 4) begin
        m_state = 1; m_miss = 0; m_armed = 0; m_per = 0;
        m_pred = nxt_m(v);
      end else begin
        m_pred = nxt_m(m_pred);
      end
    end else begin
      m_miss = 0;
      m_pred = nxt_m(m_pred);
      if (v == 16'hACE1) begin
        if (m_armed) begin
          m_period = m_per;
          m_vld = 1;
        end
        m_per = 1;
        m_armed = 1;
      end else if (m_armed && m_per < 131071) begin
        m_per++;
      end
    end
  endtask

  task automatic drive(input bit en, input logic [15:0] v);
    @(negedge CLK);
    sample_en = en;
    q = v;
    @(posedge CLK);
    model_step(en, v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    n_RESET = 1'b0;
    sample_en = 1'b0;
    model_reset();
    #2;
    @(negedge CLK);
    n_RESET = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", dut_vec, 36'd0);
    end
    @(negedge CLK);
    n_RESET = 1'b1;
  endtask

  task automatic test_acquire();
    logic [15:0] vals [4];
    bit exp_lock [4];
    vals = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
    exp_lock = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i]);
      checks++;
      if (locked !== exp_lock[i] || err_count !== 16'd0 || period_vld !== 1'b0) begin
        failures++;
        $display("FAIL acquire_%0d got lock=%b err=%0d vld=%b want lock=%b err=0 vld=0",
                 i, locked, err_count, period_vld, exp_lock[i]);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL acquire_model_%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_single_error();
    do_reset();
    drive(1'b1, seq[0]);
    drive(1'b1, seq[1]);
    drive(1'b1, seq[2]);
    drive(1'b1, 16'h389D);
    for (int i = 4; i < 10; i++) begin
      drive(1'b1, seq[i]);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL single_err_model_%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL single_err got err=%0d lock=%b want err=1 lock=1", err_count, locked);
    end
  endtask

  task automatic test_resync();
    bit exp_lock [4];
    exp_lock = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    drive(1'b1, seq[0]);
    drive(1'b1, seq[1]);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[2 + i] ^ 16'h0001);
      checks++;
      if (err_count !== 16'(i + 1) || locked !== exp_lock[i]) begin
        failures++;
        $display("FAIL resync_bad_%0d got err=%0d lock=%b want err=%0d lock=%b",
                 i, err_count, locked, i + 1, exp_lock[i]);
      end
    end
    drive(1'b1, seq[6]);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL resync_first_good got lock=%b want lock=0", locked);
    end
    drive(1'b1, seq[7]);
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd4) begin
      failures++;
      $display("FAIL resync_relock got lock=%b err=%0d want lock=1 err=4", locked, err_count);
    end
  endtask

  task automatic test_gaps();
    int idx;
    do_reset();
    drive(1'b1, seq[0]);
    drive(1'b1, seq[1]);
    idx = 2;
    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 16'($urandom));
        checks++;
        if (dut_vec !== model_vec()) begin
          failures++;
          $display("FAIL gap_hold_%0d got=%h want=%h", i, dut_vec, model_vec());
        end
      end
      drive(1'b1, seq[idx]);
      idx++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL gap_sample_%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL gap_final got lock=%b err=%0d want lock=1 err=0", locked, err_count);
    end
    drive(1'b1, 16'h1234);
    @(posedge CLK);
    #3;
    n_RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 36'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", dut_vec, 36'd0);
    end
    @(negedge CLK);
    sample_en = 1'b0;
    n_RESET = 1'b1;
  endtask

  task automatic test_period();
    int pulses, pulse_at;
    logic [16:0] seen;
    pulses = 0; pulse_at = -1; seen = '0;
    do_reset();
    drive(1'b1, seq[65533]);
    drive(1'b1, seq[65534]);
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, seq[i % 65535]);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL period_model_%0d got=%h want=%h", i, dut_vec, model_vec());
      end
      if (period_vld === 1'b1) begin
        pulses++;
        pulse_at = i;
        seen = period;
      end
    end
    checks++;
    if (pulses !== 1 || pulse_at !== 65535 || seen !== 17'd65535 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL period_loop got pulses=%0d at=%0d period=%0d err=%0d want pulses=1 at=65535 period=65535 err=0",
               pulses, pulse_at, seen, err_count);
    end
  endtask

  task automatic test_zero();
    bit want;
`ifdef LFSR_MON_ZERO_DET_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    do_reset();
    drive(1'b1, seq[0]);
    drive(1'b1, seq[1]);
    drive(1'b1, 16'h0000);
    for (int i = 3; i < 6; i++) drive(1'b1, seq[i]);
    checks++;
    if (zero_lock !== want || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL zero_lock got zl=%b vec=%h want zl=%b vec=%h", zero_lock, dut_vec, want, model_vec());
    end
    do_reset();
    checks++;
    if (zero_lock !== 1'b0) begin
      failures++;
      $display("FAIL zero_clear got zl=%b want zl=0", zero_lock);
    end
  endtask

  task automatic test_random();
    int idx, burst;
    do_reset();
    idx = $urandom_range(0, 65534);
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [15:0] v;
      r = $urandom_range(0, 99);
      if (burst > 0) begin
        v = seq[idx] ^ 16'($urandom_range(1, 65535));
        idx = (idx + 1) % 65535;
        burst--;
        drive(1'b1, v);
      end else if (r < 15) begin
        drive(1'b0, 16'($urandom));
      end else if (r < 25) begin
        v = seq[idx] ^ 16'($urandom_range(1, 65535));
        idx = (idx + 1) % 65535;
        drive(1'b1, v);
      end else if (r < 28) begin
        idx = (idx + 1) % 65535;
        drive(1'b1, 16'h0000);
      end else begin
        if (r == 99) burst = 4;
        drive(1'b1, seq[idx]);
        idx = (idx + 1) % 65535;
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL random_%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    seq[0] = 16'hACE1;
    for (int i = 1; i < 65535; i++) seq[i] = nxt_m(seq[i - 1]);
    model_reset();
    repeat (2) @(negedge CLK);
    n_RESET = 1'b1;
    test_reset();
    test_acquire();
    test_single_error();
    test_resync();
    test_gaps();
    test_zero();
    test_random();
    test_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
